// File: rtl/packet_pkg.sv
// Shared AXI-Stream beat types and helpers for the RX packet path.
//   axis_beat_t     : one stored beat {tdata, tkeep, tlast, tuser}
//   rx_buf_state_e  : write-side FSM states of rx_pkt_buffer
//   keep_bytes()    : number of valid bytes in a beat (popcount of tkeep)
package packet_pkg;

  localparam int AXIS_DATA_W = 512;
  localparam int AXIS_USER_W = 48;
  localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic                   tlast;
    logic [AXIS_USER_W-1:0] tuser;
  } axis_beat_t;

  typedef enum logic [1:0] {
    IDLE,
    STORE,
    DISCARD
  } rx_buf_state_e;

  function automatic logic [15:0] keep_bytes(input logic [AXIS_KEEP_W-1:0] keep);
    logic [15:0] n;
    n = '0;
    for (int unsigned i = 0; i < AXIS_KEEP_W; i++) begin
      n = n + 16'(keep[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rx_pkt_buffer_ram.sv
// Simple dual-port beat RAM with registered read for rx_pkt_buffer.
//   clk, rst_n          : clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr       : read request; rd_data updates the cycle after and
//                         holds while rd_en is low (it doubles as the
//                         m_axis output register)
module rx_pkt_buffer_ram
  import packet_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  axis_beat_t               wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output axis_beat_t               rd_data
);

  axis_beat_t mem_q [DEPTH];
  axis_beat_t rd_data_q;
  axis_beat_t rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/rx_pkt_buffer.sv
// Store-and-forward RX packet FIFO between filter_rx_pipeline and QDMA C2H.
// A packet becomes visible on m_axis only after its tlast beat is stored;
// packets that overflow the buffer are discarded whole and counted.
//   aclk, aresetn         : 250 MHz clock, async active-low reset
//   s_axis_*              : input stream (tready is 1 after reset)
//   m_axis_*              : output stream, first-word-fall-through
//   fwd_pkt_count         : packets completed on m_axis
//   drop_pkt_count        : packets discarded on overflow
//   fill_level            : committed plus in-progress stored beats
// Optional macro RX_PKT_BUFFER_LEN_EN: per-packet byte length in
// m_axis_tuser[15:0], with a MAX_PKTS-entry length FIFO.
module rx_pkt_buffer
  import packet_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int MAX_PKTS = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axis_tvalid,
  input  logic [AXIS_DATA_W-1:0]   s_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0]   s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic [AXIS_USER_W-1:0]   s_axis_tuser,
  output logic                     s_axis_tready,
  output logic                     m_axis_tvalid,
  output logic [AXIS_DATA_W-1:0]   m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0]   m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic [AXIS_USER_W-1:0]   m_axis_tuser,
  input  logic                     m_axis_tready,
  output logic [31:0]              fwd_pkt_count,
  output logic [31:0]              drop_pkt_count,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rx_pkt_buffer: DEPTH must be a power of 2 and >= 4");
  end
  if (MAX_PKTS < 2 || (MAX_PKTS & (MAX_PKTS - 1)) != 0) begin : g_bad_pkts
    $error("rx_pkt_buffer: MAX_PKTS must be a power of 2 and >= 2");
  end

  rx_buf_state_e state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          s_ready_q, s_ready_d;
  logic          valid_q, valid_d;
  logic [31:0]   fwd_q, fwd_d;
  logic [31:0]   drop_q, drop_d;

  logic          s_acc, full, len_block, commit;
  logic          ram_wr_en, ram_rd_en, m_hs;
  logic [PW-1:0] occ;
  axis_beat_t    wr_beat, rd_beat;

  assign s_acc   = s_axis_tvalid && s_ready_q;
  assign occ     = wr_ptr_q - rd_ptr_q;
  assign full    = (occ == DEPTH_P);
  assign wr_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};
  assign m_hs    = valid_q && m_axis_tready;

  // Write side: store the packet, commit on tlast, roll back on overflow.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    drop_d       = drop_q;
    ram_wr_en    = 1'b0;
    commit       = 1'b0;
    s_ready_d    = 1'b1;
    if (s_acc) begin
      unique case (state_q)
        IDLE, STORE: begin
          if (full || (state_q == IDLE && len_block)) begin
            wr_ptr_d = commit_ptr_q;
            drop_d   = drop_q + 32'd1;
            state_d  = s_axis_tlast ? IDLE : DISCARD;
          end else begin
            ram_wr_en = 1'b1;
            wr_ptr_d  = wr_ptr_q + PW'(1);
            if (s_axis_tlast) begin
              commit  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = STORE;
            end
          end
        end
        DISCARD: if (s_axis_tlast) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    if (commit) commit_ptr_d = wr_ptr_q + PW'(1);
  end

  // Read side: the RAM read register is the output register. rd_ptr counts
  // handshaken beats, so the beat held on m_axis still occupies its slot and
  // the next fetch address is simply the post-handshake rd_ptr.
  always_comb begin
    rd_ptr_d  = rd_ptr_q + PW'(m_hs);
    ram_rd_en = (!valid_q || m_axis_tready) && (rd_ptr_d != commit_ptr_q);
    valid_d   = ram_rd_en ? 1'b1 : (m_hs ? 1'b0 : valid_q);
    fwd_d     = fwd_q + 32'(m_hs && rd_beat.tlast);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      s_ready_q    <= 1'b0;
      valid_q      <= 1'b0;
      fwd_q        <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      s_ready_q    <= s_ready_d;
      valid_q      <= valid_d;
      fwd_q        <= fwd_d;
      drop_q       <= drop_d;
    end
  end

  rx_pkt_buffer_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (aclk),
    .rst_n   (aresetn),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (wr_beat),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr_d[AW-1:0]),
    .rd_data (rd_beat)
  );

`ifdef RX_PKT_BUFFER_LEN_EN
  localparam int LW = $clog2(MAX_PKTS) + 1;

  logic [15:0]   len_mem_q [MAX_PKTS];
  logic [LW-1:0] lwr_q, lwr_d, lrd_q, lrd_d;
  logic [15:0]   acc_q, acc_d, pkt_len;

  // Running byte count; a beat accepted in IDLE starts a new packet.
  always_comb begin
    pkt_len   = ((state_q == IDLE) ? 16'd0 : acc_q) + keep_bytes(s_axis_tkeep);
    acc_d     = ram_wr_en ? pkt_len : acc_q;
    lwr_d     = lwr_q + LW'(commit);
    lrd_d     = lrd_q + LW'(m_hs && rd_beat.tlast);
    len_block = ((lwr_q - lrd_q) == LW'(MAX_PKTS));
  end

  always_ff @(posedge aclk) begin
    if (commit) len_mem_q[lwr_q[LW-2:0]] <= pkt_len;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lwr_q <= '0;
      lrd_q <= '0;
      acc_q <= '0;
    end else begin
      lwr_q <= lwr_d;
      lrd_q <= lrd_d;
      acc_q <= acc_d;
    end
  end

  // Head of the length FIFO belongs to the packet currently on m_axis.
  assign m_axis_tuser = {rd_beat.tuser[AXIS_USER_W-1:16],
                         valid_q ? len_mem_q[lrd_q[LW-2:0]] : 16'd0};
`else
  assign len_block    = 1'b0;
  assign m_axis_tuser = rd_beat.tuser;
`endif

  assign s_axis_tready  = s_ready_q;
  assign m_axis_tvalid  = valid_q;
  assign m_axis_tdata   = rd_beat.tdata;
  assign m_axis_tkeep   = rd_beat.tkeep;
  assign m_axis_tlast   = rd_beat.tlast;
  assign fwd_pkt_count  = fwd_q;
  assign drop_pkt_count = drop_q;
  assign fill_level     = occ;

endmodule

// File: tb/tb_rx_pkt_buffer.sv
module tb_rx_pkt_buffer;

  localparam int DEPTH    = 64;
  localparam int MAX_PKTS = 16;
`ifdef RX_PKT_BUFFER_LEN_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
    logic [47:0]  u;
  } beat_t;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         s_axis_tvalid = 1'b0;
  logic [511:0] s_axis_tdata = '0;
  logic [63:0]  s_axis_tkeep = '0;
  logic         s_axis_tlast = 1'b0;
  logic [47:0]  s_axis_tuser = '0;
  logic         s_axis_tready;
  logic         m_axis_tvalid;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic [47:0]  m_axis_tuser;
  logic         m_axis_tready = 1'b1;
  logic [31:0]  fwd_pkt_count;
  logic [31:0]  drop_pkt_count;
  logic [$clog2(DEPTH):0] fill_level;

  always #2 aclk = ~aclk;

  rx_pkt_buffer #(
    .DEPTH    (DEPTH),
    .MAX_PKTS (MAX_PKTS)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tuser   (s_axis_tuser),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tready  (m_axis_tready),
    .fwd_pkt_count  (fwd_pkt_count),
    .drop_pkt_count (drop_pkt_count),
    .fill_level     (fill_level)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_beat(input string nm, input beat_t act, input beat_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got l=%0b u=%h k=%h d=%h expected l=%0b u=%h k=%h d=%h",
               nm, act.l, act.u, act.k, act.d, exp.l, exp.u, exp.k, exp.d);
    end
  endtask

  // Behavioural model: packets as queues of beats. Occupancy is the beats of
  // the packet being received plus every committed beat not yet handshaken.
  beat_t exp_q[$];
  beat_t cur[$];
  bit    discarding = 1'b0;
  int    m_pkts = 0;
  int    m_fwd = 0;
  int    m_drop = 0;
  int    n_out = 0;
  bit    out_mid = 1'b0;
  bit    chk_en = 1'b0;
  bit    p_valid = 1'b0;
  bit    p_ready = 1'b0;
  beat_t p_beat;

  function automatic void model_commit();
    int len;
    beat_t b;
    len = 0;
    foreach (cur[i]) len += $countones(cur[i].k);
    foreach (cur[i]) begin
      b = cur[i];
      if (LEN_EN) b.u[15:0] = 16'(len);
      exp_q.push_back(b);
    end
    cur.delete();
    m_pkts++;
  endfunction

  function automatic void model_input(input beat_t in, input int occ);
    if (discarding) begin
      if (in.l) discarding = 1'b0;
    end else if (cur.size() == 0 && (occ == DEPTH || (LEN_EN && m_pkts == MAX_PKTS))) begin
      m_drop++;
      discarding = !in.l;
    end else if (occ == DEPTH) begin
      m_drop++;
      cur.delete();
      discarding = !in.l;
    end else begin
      cur.push_back(in);
      if (in.l) model_commit();
    end
  endfunction

  always @(negedge aclk) begin
    if (chk_en) begin
      int occ;
      bit do_pop;
      beat_t got;
      beat_t b;
      occ = cur.size() + exp_q.size();
      got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
      check("fill_level", 64'(fill_level), 64'(occ));
      check("fwd_pkt_count", 64'(fwd_pkt_count), 64'(m_fwd));
      check("drop_pkt_count", 64'(drop_pkt_count), 64'(m_drop));
      check("s_axis_tready", 64'(s_axis_tready), 64'd1);
      if (p_valid && !p_ready) begin
        check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        check_beat("stall_hold", got, p_beat);
      end
      if (out_mid) check("tvalid_mid_pkt", 64'(m_axis_tvalid), 64'd1);
      do_pop = 1'b0;
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) check("unexpected_beat", 64'(m_axis_tvalid), 64'd0);
        else begin
          check_beat("out_beat", got, exp_q[0]);
          do_pop = m_axis_tready;
        end
      end
      if (s_axis_tvalid && s_axis_tready)
        model_input({s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser}, occ);
      if (do_pop) begin
        b = exp_q.pop_front();
        n_out++;
        out_mid = !b.l;
        if (b.l) begin
          m_fwd++;
          m_pkts--;
        end
      end
      p_valid = m_axis_tvalid;
      p_ready = m_axis_tready;
      p_beat  = got;
    end
  end

  task automatic send_beat(input logic [63:0] keep, input logic last);
    s_axis_tvalid = 1'b1;
    for (int w = 0; w < 16; w++) s_axis_tdata[w*32 +: 32] = $urandom;
    s_axis_tkeep = keep;
    s_axis_tlast = last;
    s_axis_tuser = {16'($urandom), 32'($urandom)};
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int gap_max);
    logic [63:0] k;
    for (int i = 0; i < len; i++) begin
      k = (i == len - 1) ? {32'($urandom), 32'($urandom)} : '1;
      send_beat(k, i == len - 1);
      if (gap_max > 0 && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, gap_max)) @(posedge aclk);
      #0;
    end
  endtask

  task automatic wait_valid(input string nm, input int max_cyc);
    int c;
    c = 0;
    @(negedge aclk);
    while (!m_axis_tvalid && c < max_cyc) begin
      @(negedge aclk);
      c++;
    end
    if (!m_axis_tvalid) check({nm, "_timeout"}, 64'(m_axis_tvalid), 64'd1);
  endtask

  task automatic drain(input string nm, input int max_cyc);
    int c;
    c = 0;
    @(negedge aclk);
    while ((exp_q.size() != 0 || m_axis_tvalid) && c < max_cyc) begin
      @(negedge aclk);
      c++;
    end
    check({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({nm, "_fill_zero"}, 64'(fill_level), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int f0, d0, o0;
    bit t5_done;

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_s_tready", 64'(s_axis_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_fwd", 64'(fwd_pkt_count), 64'd0);
    check("rst_drop", 64'(drop_pkt_count), 64'd0);
    check("rst_fill", 64'(fill_level), 64'd0);
    check("rst_tdata", m_axis_tdata[63:0], 64'd0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1 chk_en = 1'b1;

    // 1: single 1-beat packet, output valid in the 2nd cycle after input
    send_beat('1, 1'b1);
    @(negedge aclk);
    check("t1_valid_commit_cycle", 64'(m_axis_tvalid), 64'd0);
    @(negedge aclk);
    check("t1_valid_latency", 64'(m_axis_tvalid), 64'd1);
    check("t1_tlast", 64'(m_axis_tlast), 64'd1);
    @(negedge aclk);
    check("t1_fwd", 64'(fwd_pkt_count), 64'd1);
    check("t1_drop", 64'(drop_pkt_count), 64'd0);

    // 2: three back-to-back 4-beat packets, 12 contiguous beats
    fork
      begin
        for (int p = 0; p < 3; p++) send_pkt(4, 0);
      end
      begin
        wait_valid("t2", 30);
        for (int i = 0; i < 12; i++) begin
          check("t2_contig_valid", 64'(m_axis_tvalid), 64'd1);
          check("t2_tlast_pos", 64'(m_axis_tlast), 64'((i % 4) == 3));
          @(negedge aclk);
        end
      end
    join
    drain("t2", 50);
    check("t2_fwd", 64'(fwd_pkt_count), 64'd4);

    // 3: stalled output, 40-beat packet stored, 30-beat packet dropped
    m_axis_tready = 1'b0;
    o0 = n_out;
    send_pkt(40, 0);
    @(negedge aclk);
    check("t3_fill_40", 64'(fill_level), 64'd40);
    send_pkt(30, 0);
    @(negedge aclk);
    check("t3_fill_after_drop", 64'(fill_level), 64'd40);
    check("t3_drop", 64'(drop_pkt_count), 64'd1);
    @(posedge aclk);
    #1 m_axis_tready = 1'b1;
    drain("t3", 200);
    check("t3_beats_out", 64'(n_out - o0), 64'd40);
    check("t3_fwd", 64'(fwd_pkt_count), 64'd5);

    // 4: 65-beat packet can never fit
    o0 = n_out;
    send_pkt(65, 0);
    repeat (4) @(negedge aclk);
    check("t4_drop", 64'(drop_pkt_count), 64'd2);
    check("t4_no_output", 64'(n_out - o0), 64'd0);
    check("t4_valid_low", 64'(m_axis_tvalid), 64'd0);
    send_pkt(2, 0);
    drain("t4", 50);
    check("t4_fwd", 64'(fwd_pkt_count), 64'd6);
    check("t4_beats_out", 64'(n_out - o0), 64'd2);

    // 5: random lengths, gaps and tready
    f0 = m_fwd;
    d0 = m_drop;
    t5_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 100; p++) begin
          if ($urandom_range(0, 19) == 0) send_pkt($urandom_range(40, 70), 3);
          else send_pkt($urandom_range(1, 16), 3);
        end
        t5_done = 1'b1;
      end
      begin
        while (!t5_done) begin
          @(posedge aclk);
          #1 m_axis_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_axis_tready = 1'b1;
    drain("t5", 3000);
    check("t5_pkts_accounted", 64'((m_fwd - f0) + (m_drop - d0)), 64'd100);

`ifdef RX_PKT_BUFFER_LEN_EN
    // 6: byte length 64 + 6 = 70 on both beats
    s_axis_tvalid = 1'b1;
    s_axis_tkeep  = 64'hFFFF_FFFF_FFFF_FFFF;
    s_axis_tlast  = 1'b0;
    @(posedge aclk);
    #1;
    s_axis_tkeep  = 64'h0000_0000_0000_003F;
    s_axis_tlast  = 1'b1;
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    wait_valid("t6", 20);
    check("t6_len_beat0", 64'(m_axis_tuser[15:0]), 64'd70);
    @(negedge aclk);
    check("t6_len_beat1", 64'(m_axis_tuser[15:0]), 64'd70);
    check("t6_tlast", 64'(m_axis_tlast), 64'd1);
    drain("t6", 20);
`endif

    repeat (3) @(negedge aclk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rx_pkt_buffer.md
Name: rx_pkt_buffer

Overview:
Store-and-forward packet FIFO that sits directly downstream of filter_rx_pipeline and upstream of the QDMA C2H AXI-Stream port, in box_250mhz.
- Releases a packet to the QDMA only once its tlast beat is stored.
- The QDMA never sees a partial packet, and filter backpressure is decoupled from QDMA stalls.
- Drops whole packets on overflow and counts them.

Parameters:
DEPTH, 64, buffer depth in 512-bit beats; power of 2, >= 4
MAX_PKTS, 16, depth of per-packet length FIFO; power of 2; used only with RX_PKT_BUFFER_LEN_EN

Ports:
aclk  input  1  clock, 250 MHz domain
aresetn  input  1  reset; asynchronous assert, active-low
s_axis_tvalid  input  1  beat valid from filter stage
s_axis_tdata  input  512  beat data, big-endian packet bytes
s_axis_tkeep  input  64  byte enables
s_axis_tlast  input  1  last beat of packet
s_axis_tuser  input  48  sideband, carried per beat
s_axis_tready  output  1  constant 1 after reset (never backpressures)
m_axis_tvalid  output  1  beat valid to QDMA
m_axis_tdata  output  512  beat data
m_axis_tkeep  output  64  byte enables
m_axis_tlast  output  1  last beat
m_axis_tuser  output  48  sideband
m_axis_tready  input  1  QDMA ready
fwd_pkt_count  output  32  packets fully sent on m_axis (tlast handshake)
drop_pkt_count  output  32  packets discarded due to overflow
fill_level  output  $clog2(DEPTH)+1  stored beats, committed plus in-progress

Behaviour:
- Reset values: all counters 0, pointers 0, m_axis_tvalid 0, s_axis_tready 0 during reset and 1 from the first cycle after deassert; other m_axis outputs 0.
- Storage: DEPTH-entry RAM of {tdata, tkeep, tlast, tuser}.
- Pointers are $clog2(DEPTH)+1 bits: wr_ptr, commit_ptr, rd_ptr. Occupancy is wr_ptr-rd_ptr, modulo arithmetic, with natural wrap.
- Write FSM states: IDLE, STORE, DISCARD.
- IDLE, accepted beat with space: write it, wr_ptr++, go to STORE. If that beat also has tlast, commit and stay in IDLE.
- STORE, accepted beat: if occupancy == DEPTH, set wr_ptr <= commit_ptr, drop_pkt_count++, go to DISCARD. If that beat has tlast, go to IDLE instead.
- STORE, beat written with tlast: commit_ptr <= wr_ptr+1, go to IDLE.
- IDLE, beat accepted while full: the packet is dropped. Counted once; go to DISCARD unless tlast.
- DISCARD: swallow beats until tlast, then IDLE. Nothing is written.
- A packet longer than DEPTH beats is always dropped.
- Read side: m_axis presents data only while rd_ptr != commit_ptr. Output register is first-word-fall-through.
- Latency: first beat of a packet is valid on m_axis 2 cycles after its tlast beat is accepted on s_axis (commit cycle, then output register).
- Streaming: full throughput, one beat per cycle, while m_axis_tready=1.
- Handshake: standard AXI-S. m_axis_* hold stable while tvalid && !tready. tvalid never deasserts mid-packet once a packet has started on m_axis.
- fwd_pkt_count increments on the m_axis tlast handshake.
- Simultaneous write commit and read of the same RAM entry is impossible: only committed entries are read.
- Simultaneous s_axis tlast commit and m_axis tlast handshake: both take effect in the same cycle.
- Counters wrap at 2^32.
- Reset mid-operation: buffer contents and any partial packet are lost. No output glitch beyond tvalid falling asynchronously.

Optional Feature:
Macro RX_PKT_BUFFER_LEN_EN.
- Defined:
  - Byte length (sum of popcount(tkeep) over the packet, 16 bits) is pushed into a MAX_PKTS-entry length FIFO at commit.
  - m_axis_tuser[15:0] carries that length on every beat of the packet; tuser[47:16] passes through.
  - A packet whose start finds the length FIFO full is dropped (DISCARD, drop_pkt_count++).
- Undefined: no length FIFO, tuser passes through unmodified, and the packet limit is DEPTH beats only.

Decomposition:
- packet_pkg gains:
  - typedef axis_beat_t {tdata, tkeep, tlast, tuser}
  - enum rx_buf_state_e {IDLE, STORE, DISCARD}
  - constants AXIS_DATA_W=512 and AXIS_USER_W=48
- One sub-module, rx_pkt_buffer_ram: simple dual-port, registered-read RAM of axis_beat_t.

Test Plan:
1. Single 1-beat packet, tkeep all-ones, tready=1: m_axis_tvalid rises 2 cycles after input; fwd_pkt_count=1, drop_pkt_count=0.
2. Three back-to-back 4-beat packets, tready=1: 12 contiguous output beats, tlast on beats 4, 8 and 12; fwd_pkt_count=3.
3. DEPTH=64 with tready=0, send a 40-beat then a 30-beat packet: first stored (fill_level=40), second dropped (drop_pkt_count=1). Raise tready: only 40 beats emerge.
4. 65-beat packet with tready=1: dropped, drop_pkt_count=1, no m_axis_tvalid. Following 2-beat packet forwarded normally.
5. Random tready toggling over 100 random-length packets: output equals input beat-for-beat, and data is stable during stalls.
6. With RX_PKT_BUFFER_LEN_EN, a 2-beat packet, tkeep 64'hFFFF_FFFF_FFFF_FFFF then 64'h0000_0000_0000_003F: tuser[15:0]=70 on both output beats.
